// File: rtl/action_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : action_pkg
//  Description : Shared action indices, default sizes and a one-hot to
//                binary helper for the action scheduler slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package action_pkg;

    // Default sizing of the scheduler
    localparam int DEF_N_ACTIONS = 8;
    localparam int DEF_DWELL_W   = 6;

    // Action indices of the creature core
    localparam int SLEEP     = 0;
    localparam int EAT       = 1;
    localparam int PLAY      = 2;
    localparam int SMILE     = 3;
    localparam int BABBLE    = 4;
    localparam int KICK_LEGS = 5;
    localparam int IDLE      = 6;
    localparam int CRY       = 7;

    // Binary index of a one-hot vector (up to 32 actions); OR-reduction so a
    // legal one-hot input maps to exactly its set bit position.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/action_scheduler_prio_pick.sv
`default_nettype none
// ============================================================================
//  Module      : prio_pick
//  Description : Lowest-index-first picker. Reports whether any mask bit is
//                set and the index of the lowest set bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_pick
    import action_pkg::*;
#(
    parameter int N     = DEF_N_ACTIONS,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is written last and wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/action_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : action_scheduler
//  Description : Selects one active action out of N_ACTIONS with minimum and
//                maximum dwell, preemption, sleep lock and a change strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module action_scheduler
    import action_pkg::*;
#(
    parameter int N_ACTIONS    = DEF_N_ACTIONS,
    parameter int IDX_W        = $clog2(N_ACTIONS),
    parameter int DWELL_W      = DEF_DWELL_W,
    parameter int MIN_DWELL    = 4,
    parameter int MAX_DWELL    = 40,
    parameter int SLEEP_IDX    = SLEEP,
    parameter int FALLBACK_IDX = IDLE,
    parameter int RESET_IDX    = SMILE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 force_sleep,
    input  logic                 force_wake,
    input  logic [N_ACTIONS-1:0] req,
    input  logic [N_ACTIONS-1:0] preempt,
    input  logic [N_ACTIONS-1:0] stay,
    output logic [N_ACTIONS-1:0] action,
    output logic [IDX_W-1:0]     action_idx,
    output logic                 changed,
    output logic [DWELL_W-1:0]   dwell
);

    localparam logic [IDX_W-1:0]     c_sleep_idx    = IDX_W'(SLEEP_IDX);
    localparam logic [IDX_W-1:0]     c_fallback_idx = IDX_W'(FALLBACK_IDX);
    localparam logic [IDX_W-1:0]     c_reset_idx    = IDX_W'(RESET_IDX);
    localparam logic [N_ACTIONS-1:0] c_reset_oh     =
        {{(N_ACTIONS-1){1'b0}}, 1'b1} << RESET_IDX;
    localparam logic [DWELL_W-1:0]   c_min_dwell    = DWELL_W'(MIN_DWELL);
    localparam logic [DWELL_W-1:0]   c_max_dwell    = DWELL_W'(MAX_DWELL);
    localparam logic [DWELL_W-1:0]   c_dwell_sat    = {DWELL_W{1'b1}};
    localparam logic                 c_timeout_en   = (MAX_DWELL != 0);

    logic [N_ACTIONS-1:0] r_action;
    logic [IDX_W-1:0]     r_action_idx;
    logic                 r_changed;
    logic [DWELL_W-1:0]   r_dwell;

    logic [N_ACTIONS-1:0] w_pre_mask;
    logic [N_ACTIONS-1:0] w_req_mask;
    logic                 w_pre_found;
    logic [IDX_W-1:0]     w_pre_idx;
    logic                 w_req_found;
    logic [IDX_W-1:0]     w_req_idx;
    logic                 w_asleep;
    logic                 w_min_met;
    logic                 w_max_hit;
    logic                 w_stay_cur;
    logic [IDX_W-1:0]     w_next_idx;
    logic [N_ACTIONS-1:0] w_next_oh;
    logic                 w_change;

    // The active action is masked out so a request for it never retriggers it
    assign w_pre_mask = req & preempt & ~r_action;
    assign w_req_mask = req & ~r_action;

    prio_pick #(
        .N     (N_ACTIONS),
        .IDX_W (IDX_W)
    ) u_pick_preempt (
        .mask  (w_pre_mask),
        .found (w_pre_found),
        .idx   (w_pre_idx)
    );

    prio_pick #(
        .N     (N_ACTIONS),
        .IDX_W (IDX_W)
    ) u_pick_req (
        .mask  (w_req_mask),
        .found (w_req_found),
        .idx   (w_req_idx)
    );

    assign w_asleep   = (r_action_idx == c_sleep_idx);
    assign w_min_met  = (r_dwell >= c_min_dwell);
    assign w_max_hit  = c_timeout_en && (r_dwell >= c_max_dwell);
    assign w_stay_cur = |(stay & r_action);

    // Strict-priority selection of the next action; first match wins
    always_comb begin
        w_next_idx = r_action_idx;
        if (force_sleep) begin
            w_next_idx = c_sleep_idx;
        end else if (force_wake && w_asleep) begin
            w_next_idx = c_fallback_idx;
        end else if (w_pre_found) begin
            w_next_idx = w_pre_idx;
        end else if (!w_asleep && w_min_met && w_req_found) begin
            w_next_idx = w_req_idx;
        end else if (!w_asleep && w_max_hit) begin
            // Already in fallback this resolves to a hold
            w_next_idx = c_fallback_idx;
        end else if (!w_asleep && w_min_met && !w_stay_cur) begin
            w_next_idx = c_fallback_idx;
        end
    end

    // One-hot image of the selected index
    always_comb begin
        w_next_oh             = '0;
        w_next_oh[w_next_idx] = 1'b1;
    end

    assign w_change = (w_next_idx != r_action_idx);

    // Action registers, change strobe and saturating dwell counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_action     <= c_reset_oh;
            r_action_idx <= c_reset_idx;
            r_changed    <= 1'b0;
            r_dwell      <= '0;
        end else begin
            r_action     <= w_next_oh;
            r_action_idx <= w_next_idx;
            r_changed    <= w_change;
            if (w_change) begin
                r_dwell <= '0;
            end else if (r_dwell != c_dwell_sat) begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    assign action     = r_action;
    assign action_idx = r_action_idx;
    assign changed    = r_changed;
    assign dwell      = r_dwell;

endmodule
`default_nettype wire

// File: tb/tb_action_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_action_scheduler
//  Description : Directed self-checking bench for action_scheduler with
//                default parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_action_scheduler;
    import action_pkg::*;

    logic       clk;
    logic       rst;
    logic       force_sleep;
    logic       force_wake;
    logic [7:0] req;
    logic [7:0] preempt;
    logic [7:0] stay;
    logic [7:0] action;
    logic [2:0] action_idx;
    logic       changed;
    logic [5:0] dwell;

    int tests;
    int fails;
    int bad_cycles;

    action_scheduler u_dut (
        .clk         (clk),
        .rst         (rst),
        .force_sleep (force_sleep),
        .force_wake  (force_wake),
        .req         (req),
        .preempt     (preempt),
        .stay        (stay),
        .action      (action),
        .action_idx  (action_idx),
        .changed     (changed),
        .dwell       (dwell)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) begin
            step();
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int idx, input int dw, input logic chg);
        chk({tag, " idx"}, 32'(action_idx), 32'(idx));
        chk({tag, " onehot"}, 32'(action), 32'(1) << idx);
        chk({tag, " dwell"}, 32'(dwell), 32'(dw));
        chk({tag, " changed"}, 32'(changed), 32'(chg));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        bad_cycles  = 0;
        rst         = 1'b1;
        force_sleep = 1'b0;
        force_wake  = 1'b0;
        req         = '0;
        preempt     = '0;
        stay        = 8'hFF;

        // 1. Reset state, then counting dwell while holding
        steps(2);
        chk_state("reset", SMILE, 0, 1'b0);
        chk("reset idx helper", 32'(onehot_to_idx({24'b0, action})), 32'(action_idx));
        rst = 1'b0;
        step();
        chk_state("hold d1", SMILE, 1, 1'b0);
        step();
        chk_state("hold d2", SMILE, 2, 1'b0);

        // 2. Normal request waits for minimum dwell, lowest index wins
        req = 8'b0000_0110;
        step();
        chk_state("req d3", SMILE, 3, 1'b0);
        step();
        chk_state("req d4", SMILE, 4, 1'b0);
        step();
        chk_state("req taken", EAT, 0, 1'b1);
        req = '0;
        step();
        chk_state("req after", EAT, 1, 1'b0);

        // 3. Preemption bypasses minimum dwell; plain request waits
        do_reset();
        step();
        chk("pre dwell1", 32'(dwell), 32'd1);
        req     = 8'h80;
        preempt = 8'h80;
        step();
        chk_state("preempt", CRY, 0, 1'b1);
        preempt = '0;
        req     = '0;
        do_reset();
        step();
        req = 8'h80;
        steps(3);
        chk_state("nopre wait", SMILE, 4, 1'b0);
        step();
        chk_state("nopre taken", CRY, 0, 1'b1);
        req = '0;

        // 4. Sleep lock, wake, and force_sleep priority
        force_sleep = 1'b1;
        step();
        chk_state("sleep", SLEEP, 0, 1'b1);
        force_sleep = 1'b0;
        req         = 8'hFE;
        for (int k = 0; k < 100; k++) begin
            step();
            if (action_idx !== 3'(SLEEP)) bad_cycles++;
        end
        chk("sleep lock cycles", 32'(bad_cycles), 32'd0);
        chk_state("sleep sat", SLEEP, 63, 1'b0);
        force_wake = 1'b1;
        step();
        chk_state("wake", IDLE, 0, 1'b1);
        req = '0;
        step();
        chk_state("wake ignored awake", IDLE, 1, 1'b0);
        force_sleep = 1'b1;
        step();
        chk_state("sleep beats wake", SLEEP, 0, 1'b1);
        force_sleep = 1'b0;
        force_wake  = 1'b0;
        req         = 8'h20;
        preempt     = 8'h20;
        step();
        chk_state("preempt from sleep", KICK_LEGS, 0, 1'b1);

        // 5. Maximum dwell timeout, then fallback holds and saturates
        req     = 8'h04;
        preempt = 8'h04;
        step();
        chk_state("enter play", PLAY, 0, 1'b1);
        req     = '0;
        preempt = '0;
        steps(40);
        chk_state("play d40", PLAY, 40, 1'b0);
        step();
        chk_state("timeout", IDLE, 0, 1'b1);
        steps(70);
        chk_state("idle sat", IDLE, 63, 1'b0);

        // 6. Release after minimum dwell, then asynchronous reset
        req     = 8'h04;
        preempt = 8'h04;
        step();
        req     = '0;
        preempt = '0;
        steps(2);
        chk_state("play d2", PLAY, 2, 1'b0);
        stay = 8'hFB;
        step();
        chk_state("release d3", PLAY, 3, 1'b0);
        step();
        chk_state("release d4", PLAY, 4, 1'b0);
        step();
        chk_state("released", IDLE, 0, 1'b1);
        stay    = 8'hFF;
        req     = 8'h04;
        preempt = 8'h04;
        step();
        req     = '0;
        preempt = '0;
        step();
        chk_state("pre reset", PLAY, 1, 1'b0);
        rst = 1'b1;
        #2;
        chk_state("async reset", SMILE, 0, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk_state("post reset", SMILE, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/action_scheduler.md
Name: action_scheduler

Overview:
- Parametrised successor to the fixed 8-action regulator: selects one active action out of N_ACTIONS from per-action request, stay and preempt vectors computed upstream.
- Adds minimum and maximum dwell time, preemption, a sleep lock and a change strobe.
- Sits between the stimulus/emotion decode logic and the display/output driver in the creature core.
- Upstream decode keeps producing the "ready_to_*" conditions. This block owns all sequencing.

Parameters:
- N_ACTIONS, 8, number of actions; one-hot width; minimum 2.
- IDX_W, $clog2(N_ACTIONS), width of the action index.
- DWELL_W, 6, width of the dwell counter.
- MIN_DWELL, 4, cycles an action must be held before a non-preempting request may replace it.
- MAX_DWELL, 40, cycles after which any non-sleep action falls back; 0 disables the limit; must be < 2^DWELL_W.
- SLEEP_IDX, 0, index of the sleep action.
- FALLBACK_IDX, 6, index of the idle/fallback action.
- RESET_IDX, 3, action index loaded on reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- force_sleep  in  1  enter SLEEP_IDX next cycle.
- force_wake  in  1  leave sleep to FALLBACK_IDX next cycle.
- req  in  N_ACTIONS  action i requested; bit 0 has highest priority.
- preempt  in  N_ACTIONS  request i may bypass MIN_DWELL; only effective together with req[i].
- stay  in  N_ACTIONS  current action i wishes to continue.
- action  out  N_ACTIONS  registered one-hot current action.
- action_idx  out  IDX_W  registered binary index of action.
- changed  out  1  registered one-cycle pulse, high in the first cycle of a new action.
- dwell  out  DWELL_W  cycles spent in the current action; saturating.

Behaviour:
- Reset (async, rst=1):
  - action = one-hot(RESET_IDX), action_idx = RESET_IDX.
  - dwell = 0, changed = 0.
  - Outputs are held while rst is high; normal operation starts on the first clk edge after rst falls.
- The next action is evaluated each cycle in strict priority order. The first match wins:
  1. force_sleep -> SLEEP_IDX. This applies even if already asleep, in which case it is a no-change.
  2. force_wake, with current = SLEEP_IDX -> FALLBACK_IDX. force_wake is ignored when not asleep.
  3. Preempt: the lowest i with req[i] & preempt[i] & i != current -> i. Allowed from sleep.
  4. Normal request: the lowest i with req[i] & i != current -> i. Only if current != SLEEP_IDX and dwell >= MIN_DWELL.
  5. Timeout: MAX_DWELL != 0, current != SLEEP_IDX and dwell >= MAX_DWELL -> FALLBACK_IDX. If current == FALLBACK_IDX, no change.
  6. Release: stay[current] == 0, current != SLEEP_IDX and dwell >= MIN_DWELL -> FALLBACK_IDX.
  7. Otherwise hold the current action.
- Requests for the action already active are ignored for selection, so they never retrigger it.
- A "change" means next index != current index. When a change occurs:
  - dwell <= 0 and changed <= 1 in the same edge.
  - Otherwise changed <= 0 and dwell <= dwell + 1, saturating at 2^DWELL_W - 1 with no wrap.
- Latency is one cycle from input to action/action_idx/changed. There is no combinational path from inputs to outputs.
- action and action_idx always agree, and exactly one bit of action is high. There is no illegal state.
- Timeout is a single event: after falling back, dwell restarts from 0, so a MAX_DWELL timeout recurs only for non-fallback actions.
- Sleep lock: from sleep, only force_sleep, force_wake or a preempting request changes state. stay/timeout/release never apply to sleep.
- Simultaneous force_sleep and force_wake: force_sleep wins.
- Reset mid-action: immediate return to RESET_IDX. No pending state is retained.

Decomposition:
- Shared package action_pkg:
  - action index localparams (SLEEP=0, EAT=1, PLAY=2, SMILE=3, BABBLE=4, KICK_LEGS=5, IDLE=6, CRY=7).
  - Default N_ACTIONS and DWELL_W.
  - A function onehot_to_idx.
- One sub-module: prio_pick, a parametrised lowest-index-first picker. Inputs: mask vector. Outputs: found flag and index.
  - It is instantiated twice: once for preempt&req and once for req, each with the current action masked out.
- Next-state logic and counters stay in action_scheduler.

Test Plan:
1. Reset with default params -> action=8'b0000_1000, action_idx=3, dwell=0, changed=0; then idle inputs with stay=8'hFF -> holds 3, dwell increments 1,2,3… and saturates at 63.
2. req=8'b0000_0110 at dwell=2 -> no change until dwell=4; then action_idx=1 (lowest index wins), changed high for exactly 1 cycle, dwell=0.
3. At dwell=1 in action 3, req[7]=1 & preempt[7]=1 -> action_idx=7 next cycle; the same request without preempt waits until dwell=4.
4. force_sleep -> idx 0; req=8'hFE without preempt held for 100 cycles -> stays 0. force_wake -> idx 6. force_sleep and force_wake together -> idx 0.
5. Action 2 with stay[2]=1 and no requests -> fallback to idx 6 when dwell reaches 40. Stay at 6 afterwards, with dwell counting on.
6. stay[2] dropped at dwell=2 -> stays in 2 until dwell=4, then moves to 6. Assert rst mid-action -> outputs return to idx 3 asynchronously, before the next clk edge.
